// File: rtl/ddr2_init_seq_pkg.sv
// Shared state encoding, DRAM command encodings and mode-register helpers
// for the DDR2 power-up sequencer.
package ddr2_init_seq_pkg;

    typedef enum logic [3:0] {
        StIdle, StCkeWait, StNopWait, StPre1, StEmrs2, StEmrs3, StEmrs1, StMrsDll,
        StPre2, StRef1, StRef2, StMrs, StOcdDef, StOcdExit, StDllWait, StDone
    } init_state_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    localparam int unsigned A_PRE_ALL = 10;
    localparam int unsigned A_DLL_RST = 8;
    localparam logic [15:0] EMR_OCD_DEFAULT = 16'h0380;
    localparam logic [2:0]  MR_BL4 = 3'b010;

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned at_least_one(int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [15:0] mr_word(int unsigned cl, int unsigned wr, logic dll_rst);
        logic [15:0] w;
        w            = '0;
        w[11:9]      = 3'(wr - 1);
        w[A_DLL_RST] = dll_rst;
        w[6:4]       = 3'(cl);
        w[2:0]       = MR_BL4;
        return w;
    endfunction

    // Command chain order once CKE is high.
    function automatic init_state_e next_step(init_state_e s);
        case (s)
            StNopWait: return StPre1;
            StPre1:    return StEmrs2;
            StEmrs2:   return StEmrs3;
            StEmrs3:   return StEmrs1;
            StEmrs1:   return StMrsDll;
            StMrsDll:  return StPre2;
            StPre2:    return StRef1;
            StRef1:    return StRef2;
            StRef2:    return StMrs;
            StMrs:     return StOcdDef;
            StOcdDef:  return StOcdExit;
            default:   return StDllWait;
        endcase
    endfunction

endpackage

// File: rtl/ddr2_init_timer.sv
// Loadable down-counter that saturates at zero; zero flag is combinational
// from the count.
module ddr2_init_timer #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ddr2_init_seq.sv
// DDR2 power-up sequencer: holds CKE low, then issues the PRE/EMRS/MRS/REF
// programming chain and hands the bus over once the DLL has locked.
module ddr2_init_seq
    import ddr2_init_seq_pkg::*;
#(
    parameter int unsigned T_CKE_LOW  = 400,
    parameter int unsigned T_NOP_PRE  = 100,
    parameter int unsigned T_RP       = 4,
    parameter int unsigned T_MRD      = 2,
    parameter int unsigned T_RFC      = 26,
    parameter int unsigned T_DLLK     = 200,
    parameter int unsigned CL         = 5,
    parameter int unsigned WR         = 6,
    parameter int unsigned BA_WIDTH   = 3,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter logic [15:0] EMR1_BASE  = 16'h000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cke,
    output logic                  cs_n,
    output logic                  ras_n,
    output logic                  cas_n,
    output logic                  we_n,
    output logic [BA_WIDTH-1:0]   ba,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  odt
);

    localparam int unsigned CKE_E  = at_least_one(T_CKE_LOW);
    localparam int unsigned NOP_E  = at_least_one(T_NOP_PRE);
    localparam int unsigned RP_E   = at_least_one(T_RP);
    localparam int unsigned MRD_E  = at_least_one(T_MRD);
    localparam int unsigned RFC_E  = at_least_one(T_RFC);
    localparam int unsigned DLLK_E = at_least_one(T_DLLK);
    localparam int unsigned MAX_T  = max_u(max_u(max_u(CKE_E, NOP_E), max_u(RP_E, MRD_E)),
                                           max_u(RFC_E, DLLK_E));
    localparam int unsigned TW     = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] LD_CKE = TW'(CKE_E - 1);
    localparam logic [TW-1:0] LD_NOP = TW'(NOP_E - 1);
    localparam logic [TW-1:0] LD_RP  = TW'(RP_E - 1);
    localparam logic [TW-1:0] LD_MRD = TW'(MRD_E - 1);
    localparam logic [TW-1:0] LD_RFC = TW'(RFC_E - 1);
    // Loaded as MRS_DLLRST goes out so DONE lands exactly T_DLLK cycles later.
    localparam logic [TW-1:0] LD_DLL = TW'(DLLK_E - 1);

    localparam logic [15:0] MR_RUN   = mr_word(CL, WR, 1'b0);
    localparam logic [15:0] MR_DLL   = mr_word(CL, WR, 1'b1);
    localparam logic [15:0] EMR1_OCD = EMR1_BASE | EMR_OCD_DEFAULT;

    init_state_e           state_q;
    init_state_e           nxt_state;
    logic                  in_cmd_q;
    logic                  wait_load, wait_zero, dll_load, dll_zero;
    logic [TW-1:0]         wait_val;
    logic [3:0]            nxt_cmd;
    logic [BA_WIDTH-1:0]   nxt_ba;
    logic [ADDR_WIDTH-1:0] nxt_addr;

    ddr2_init_timer #(.WIDTH(TW)) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wait_load),
        .load_val (wait_val),
        .zero     (wait_zero)
    );

    ddr2_init_timer #(.WIDTH(TW)) u_dll_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dll_load),
        .load_val (LD_DLL),
        .zero     (dll_zero)
    );

    // Next command and its bank/address fields.
    always_comb begin
        nxt_state = next_step(state_q);
        if (state_q == StOcdExit && dll_zero) begin
            nxt_state = StDone;
        end
        nxt_cmd  = CMD_MRS;
        nxt_ba   = '0;
        nxt_addr = '0;
        case (nxt_state)
            StPre1, StPre2: begin
                nxt_cmd             = CMD_PRE;
                nxt_addr[A_PRE_ALL] = 1'b1;
            end
            StRef1, StRef2: nxt_cmd = CMD_REF;
            StEmrs2:        nxt_ba = BA_WIDTH'(2);
            StEmrs3:        nxt_ba = BA_WIDTH'(3);
            StEmrs1: begin
                nxt_ba   = BA_WIDTH'(1);
                nxt_addr = ADDR_WIDTH'(EMR1_BASE);
            end
            StMrsDll:       nxt_addr = ADDR_WIDTH'(MR_DLL);
            StMrs:          nxt_addr = ADDR_WIDTH'(MR_RUN);
            StOcdDef: begin
                nxt_ba   = BA_WIDTH'(1);
                nxt_addr = ADDR_WIDTH'(EMR1_OCD);
            end
            StOcdExit: begin
                nxt_ba   = BA_WIDTH'(1);
                nxt_addr = ADDR_WIDTH'(EMR1_BASE);
            end
            default:        nxt_cmd = CMD_NOP;
        endcase
    end

    // The wait timer is armed at the end of each command cycle, so the next
    // command lands N+1 cycles after the previous one.
    always_comb begin
        wait_load = 1'b0;
        wait_val  = '0;
        if (state_q == StIdle) begin
            wait_load = start_i;
            wait_val  = LD_CKE;
        end else if (state_q == StCkeWait) begin
            wait_load = wait_zero;
            wait_val  = LD_NOP;
        end else if (in_cmd_q) begin
            wait_load = 1'b1;
            case (state_q)
                StPre1, StPre2: wait_val = LD_RP;
                StRef1, StRef2: wait_val = LD_RFC;
                default:        wait_val = LD_MRD;
            endcase
        end
        dll_load = (state_q == StEmrs1) && !in_cmd_q && wait_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                    <= StIdle;
            in_cmd_q                   <= 1'b0;
            busy_o                     <= 1'b0;
            done_o                     <= 1'b0;
            cke                        <= 1'b0;
            {cs_n, ras_n, cas_n, we_n} <= CMD_DESEL;
            ba                         <= '0;
            addr                       <= '0;
        end else begin
            in_cmd_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StCkeWait;
                        busy_o  <= 1'b1;
                    end
                end
                StCkeWait: begin
                    if (wait_zero) begin
                        state_q                    <= StNopWait;
                        cke                        <= 1'b1;
                        {cs_n, ras_n, cas_n, we_n} <= CMD_NOP;
                    end
                end
                StDllWait: begin
                    if (dll_zero) begin
                        state_q <= StDone;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                StDone: ;
                default: begin
                    if (in_cmd_q) begin
                        {cs_n, ras_n, cas_n, we_n} <= CMD_NOP;
                        ba                         <= '0;
                        addr                       <= '0;
                    end else if (wait_zero) begin
                        state_q                    <= nxt_state;
                        {cs_n, ras_n, cas_n, we_n} <= nxt_cmd;
                        ba                         <= nxt_ba;
                        addr                       <= nxt_addr;
                        in_cmd_q                   <= (nxt_cmd != CMD_NOP);
                        if (nxt_state == StDone) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign odt = 1'b0;

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Bench for ddr2_init_seq: reset/start vector table, then full sequences with
// random spurious starts compared against a command-timeline model.
module tb_ddr2_init_seq;

    localparam int T_CKE = 400;
    localparam int T_NOP = 100;
    localparam int T_RP  = 4;
    localparam int T_MRD = 2;
    localparam int T_RFC = 26;
    localparam int CL    = 5;
    localparam int WR    = 6;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] MRS = 4'b0000;
    localparam logic [3:0] REF = 4'b0001;

    typedef struct {
        int          off;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [13:0] addr;
    } cmd_rec_t;

    typedef struct {
        logic rst_n;
        logic start;
        logic cke;
        logic cs_n;
        logic busy;
        logic done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, start0, busy0, done0, cke0, cs0, ras0, cas0, we0, odt0;
    logic rst1_n, start1, busy1, done1, cke1, cs1, ras1, cas1, we1, odt1;
    logic [2:0]  ba0, ba1;
    logic [13:0] addr0, addr1;

    ddr2_init_seq dut0 (
        .clk(clk), .rst_n(rst0_n), .start_i(start0), .busy_o(busy0), .done_o(done0),
        .cke(cke0), .cs_n(cs0), .ras_n(ras0), .cas_n(cas0), .we_n(we0),
        .ba(ba0), .addr(addr0), .odt(odt0)
    );

    ddr2_init_seq #(.T_DLLK(400), .EMR1_BASE(16'h400)) dut1 (
        .clk(clk), .rst_n(rst1_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .cke(cke1), .cs_n(cs1), .ras_n(ras1), .cas_n(cas1), .we_n(we1),
        .ba(ba1), .addr(addr1), .odt(odt1)
    );

    logic        sel;
    logic        m_busy, m_done, m_cke, m_cs_n, m_ras_n, m_cas_n, m_we_n, m_odt;
    logic [2:0]  m_ba;
    logic [13:0] m_addr;
    assign m_busy  = sel ? busy1 : busy0;
    assign m_done  = sel ? done1 : done0;
    assign m_cke   = sel ? cke1  : cke0;
    assign m_cs_n  = sel ? cs1   : cs0;
    assign m_ras_n = sel ? ras1  : ras0;
    assign m_cas_n = sel ? cas1  : cas0;
    assign m_we_n  = sel ? we1   : we0;
    assign m_odt   = sel ? odt1  : odt0;
    assign m_ba    = sel ? ba1   : ba0;
    assign m_addr  = sel ? addr1 : addr0;

    int total = 0;
    int bad = 0;
    cmd_rec_t exp_q[$];
    cmd_rec_t obs_q[$];
    int exp_done;
    int cke_off, done_off, nocke_cnt, odt_cnt, nop_bad, seq_bad;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    function automatic void push(int off, logic [3:0] c, int b, int a);
        cmd_rec_t r;
        r.off  = off;
        r.cmd  = c;
        r.ba   = 3'(b);
        r.addr = 14'(a);
        exp_q.push_back(r);
    endfunction

    // Offsets are cycles after the start pulse is sampled.
    function automatic void build_model(input int dllk, input int emr1);
        int t, mr, mrs_dll;
        mr = (WR - 1) * 512 + CL * 16 + 2;
        exp_q.delete();
        t = T_CKE + T_NOP;
        push(t, PRE, 0, 'h400);         t += T_RP + 1;
        push(t, MRS, 2, 0);             t += T_MRD + 1;
        push(t, MRS, 3, 0);             t += T_MRD + 1;
        push(t, MRS, 1, emr1);          t += T_MRD + 1;
        mrs_dll = t;
        push(t, MRS, 0, mr + 256);      t += T_MRD + 1;
        push(t, PRE, 0, 'h400);         t += T_RP + 1;
        push(t, REF, 0, 0);             t += T_RFC + 1;
        push(t, REF, 0, 0);             t += T_RFC + 1;
        push(t, MRS, 0, mr);            t += T_MRD + 1;
        push(t, MRS, 1, emr1 | 'h380);  t += T_MRD + 1;
        push(t, MRS, 1, emr1);          t += T_MRD + 1;
        exp_done = (mrs_dll + dllk > t) ? mrs_dll + dllk : t;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst1_n = v; else rst0_n = v;
    endtask

    // Pulses start at a negedge, then samples every negedge; abort_off >= 0
    // pulls reset at that offset and checks the asynchronous drop.
    task automatic run_seq(input int budget, input int abort_off);
        int post;
        cmd_rec_t r;
        obs_q.delete();
        cke_off = -1; done_off = -1; nocke_cnt = 0; odt_cnt = 0; nop_bad = 0; seq_bad = 0;
        post = 0;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int k = 0; k < budget; k++) begin
            if (m_odt !== 1'b0) odt_cnt++;
            if (m_cs_n === 1'b0) begin
                if (m_cke !== 1'b1) nocke_cnt++;
                if ({m_cs_n, m_ras_n, m_cas_n, m_we_n} !== NOP) begin
                    r.off = k; r.cmd = {m_cs_n, m_ras_n, m_cas_n, m_we_n};
                    r.ba = m_ba; r.addr = m_addr;
                    obs_q.push_back(r);
                end else if (m_ba !== 3'd0 || m_addr !== 14'd0) begin
                    nop_bad++;
                end
            end
            if (cke_off < 0 && m_cke === 1'b1) cke_off = k;
            if (done_off < 0 && m_done === 1'b1) done_off = k;
            if (done_off >= 0) begin
                if (m_done !== 1'b1 || m_busy !== 1'b0 || m_cke !== 1'b1 ||
                    {m_cs_n, m_ras_n, m_cas_n, m_we_n} !== NOP) seq_bad++;
                post++;
                if (post == 20) break;
            end else if (m_busy !== 1'b1) begin
                seq_bad++;
            end
            if (k == abort_off) begin
                set_start(1'b0);
                set_rst(1'b0);
                #1;
                check("abort cke", m_cke, 1'b0);
                check("abort busy", m_busy, 1'b0);
                check("abort cs_n", m_cs_n, 1'b1);
                check("abort done", m_done, 1'b0);
                return;
            end
            set_start($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        set_start(1'b0);
    endtask

    task automatic compare_cmds(input string tag, input int n);
        check({tag, " ncmd"}, obs_q.size(), n);
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            check($sformatf("%s c%0d off", tag, i), obs_q[i].off, exp_q[i].off);
            check($sformatf("%s c%0d cmd", tag, i), obs_q[i].cmd, exp_q[i].cmd);
            check($sformatf("%s c%0d ba", tag, i), obs_q[i].ba, exp_q[i].ba);
            check($sformatf("%s c%0d addr", tag, i), obs_q[i].addr, exp_q[i].addr);
        end
    endtask

    task automatic compare_run(input string tag, input int dllk, input int emr1);
        build_model(dllk, emr1);
        compare_cmds(tag, exp_q.size());
        check({tag, " cke_rise"}, cke_off, T_CKE);
        check({tag, " done_rise"}, done_off, exp_done);
        check({tag, " cmd_with_cke_low"}, nocke_cnt, 0);
        check({tag, " odt_high"}, odt_cnt, 0);
        check({tag, " nop_fields"}, nop_bad, 0);
        check({tag, " busy_done_flags"}, seq_bad, 0);
    endtask

    initial begin
        int idle_bad, abort_off, n_pre;
        rst0_n = 1'b0; start0 = 1'b0; rst1_n = 1'b0; start1 = 1'b0; sel = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rst0_n = vecs[i].rst_n;
            start0 = vecs[i].start;
            @(negedge clk);
            check($sformatf("vec%0d cke", i), m_cke, vecs[i].cke);
            check($sformatf("vec%0d cs_n", i), m_cs_n, vecs[i].cs_n);
            check($sformatf("vec%0d busy", i), m_busy, vecs[i].busy);
            check($sformatf("vec%0d done", i), m_done, vecs[i].done);
        end
        start0 = 1'b0;

        // Idle with start low for 1000 cycles: reset values must hold.
        rst0_n = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (m_cke !== 1'b0 || {m_cs_n, m_ras_n, m_cas_n, m_we_n} !== 4'b1111 ||
                m_busy !== 1'b0 || m_done !== 1'b0 || m_ba !== 3'd0 || m_addr !== 14'd0 ||
                m_odt !== 1'b0) idle_bad++;
        end
        check("idle outputs stable", idle_bad, 0);

        repeat ($urandom_range(1, 20)) @(negedge clk);
        run_seq(1000, -1);
        compare_run("full", 200, 0);

        // Reset pulled somewhere in the REF1 wait, then a full rerun.
        rst0_n = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        @(negedge clk);
        build_model(200, 0);
        abort_off = $urandom_range(exp_q[6].off + 1, exp_q[7].off - 1);
        run_seq(1000, abort_off);
        n_pre = 0;
        foreach (exp_q[i]) if (exp_q[i].off <= abort_off) n_pre++;
        compare_cmds("pre_abort", n_pre);
        @(negedge clk);
        rst0_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_abort idle busy", m_busy, 1'b0);
        check("post_abort idle cke", m_cke, 1'b0);
        run_seq(1000, -1);
        compare_run("rerun", 200, 0);

        // Long DLL lock: DONE gated by the DLL timer, not the OCD exit wait.
        sel = 1'b1;
        rst1_n = 1'b1;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        run_seq(1200, -1);
        compare_run("dllk400", 400, 'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
